ram_rd_checker: RTL and testbench
=================================

# ram_rd_checker

Read-side companion to the single-port RAM write sequencer. After a `start` pulse it sweeps the RAM from address 0 to DEPTH-1 through the shared single-port interface. It streams each read word out with a valid flag and compares it against the pattern the writer stores: data = (addr + SEED) mod 2^DW. At the end it reports pass/fail, the error count and the first failing address. It sits between the RAM port mux and the board LEDs/ILA.

## Interface
- `DW`, default 8: RAM data width.
- `AW`, default 5: RAM address width.
- `DEPTH`, default 32: number of words checked. Range 1..2^AW.
- `RD_LAT`, default 1: RAM read latency in cycles. Legal values are 1 or 2.
- `SEED`, default 0: pattern offset. Must match the writer's SEED.

Ports (clock and reset first):
- `sys_clk` in 1: the single clock.
- `sys_rst` in 1: reset; asynchronous, active-high.
- `start` in 1: one-cycle request. Honoured only in IDLE.
- `ram_en` out 1: RAM enable.
- `ram_we` out 1: RAM write enable, constant 0.
- `ram_addr` out AW: RAM address.
- `ram_dout` in DW: RAM read data.
- `rd_data` out DW: registered read word.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `busy` out 1: high from the cycle after `start` until `done`, inclusive.
- `done` out 1: one-cycle completion pulse.
- `pass` out 1: high when err_cnt = 0. Valid from `done`; held until the next accepted `start`.
- `err_cnt` out AW+1: count of mismatches.
- `first_err_addr` out AW: address of the first mismatch; 0 if there was none.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - `ram_en` = 0.
  - `start` = 1 moves to READ.
  - On accept, `err_cnt`, `first_err_addr`, `pass` and the error-seen flag are cleared.
- READ:
  - `ram_en` = 1 and `ram_addr` = rd_ptr.
  - rd_ptr increments by 1 per cycle.
  - After the address DEPTH-1 cycle, the FSM moves to DRAIN and `ram_en` drops.
- DRAIN: lasts RD_LAT+1 cycles, so every in-flight read is compared.
- DONE: lasts one cycle. `done` = 1, `pass` is registered, then the FSM returns to IDLE.
- Tag pipeline: a valid bit and address travel alongside each read, RD_LAT stages deep.
- Compare: when the tag emerges, `ram_dout` is compared with (tag_addr + SEED) truncated to DW.
  - On mismatch, `err_cnt` increments.
  - If this is the first error, `first_err_addr` latches the tag address.
- `err_cnt` cannot overflow, since DEPTH ≤ 2^AW < 2^(AW+1). No saturation logic is needed.
- Reset values: every output is 0 and the FSM is in IDLE. `pass` is 0 until the first completed run.

## Timing
- Cycle numbering: `start` is sampled high at cycle 0.
  - Cycle 1: address 0 issued.
  - Cycle DEPTH: address DEPTH-1 issued.
- `ram_dout` holds the data for the address issued in cycle t during cycle t+RD_LAT.
- `rd_data`/`rd_valid` and the `err_cnt` update appear in cycle t+RD_LAT+1.
- Last `rd_valid`: cycle DEPTH+RD_LAT+1. `done`: cycle DEPTH+RD_LAT+2, when the final `err_cnt` is also valid.
- `rd_valid` is contiguous for DEPTH cycles with no gaps.
- Boundary rules:
  - `start` while busy or in DONE is ignored, not queued. It is accepted in the first IDLE cycle after `done`.
  - DEPTH = 1: a single read, and `done` at cycle RD_LAT+3.
  - Address wrap: rd_ptr never exceeds DEPTH-1, so there is no wrap even when DEPTH = 2^AW.
  - `sys_rst` mid-run: FSM, pointer, tag pipeline and all outputs clear immediately. No `done` is issued for the aborted run.

## Structure
- Shared package `ram_test_pkg`:
  - FSM state encodings.
  - The expected-pattern function (addr + SEED), shared with the writer.
  - Legal-RD_LAT check constants.
- One sub-module, `rd_tag_pipe`: the RD_LAT-deep valid/address delay line. It is parameterised by AW and RD_LAT and is reused by the writer's verify-after-write mode.
- FSM, pointer and compare/statistics logic live in the top level.

## Test plan
- Behavioural RAM preloaded with the correct pattern, DW=8, AW=5, DEPTH=32, RD_LAT=1, `start` pulse → 32 contiguous `rd_valid` words 0..31, `done` at cycle 35, `pass`=1, `err_cnt`=0.
- Same preload, with word 7 corrupted to 0xFF and word 20 to 0x00 → `err_cnt`=2, `first_err_addr`=7, `pass`=0.
- RD_LAT=2 with DEPTH=32 → first `rd_valid` at cycle 4, `done` at cycle 36, `pass`=1.
- `start` re-pulsed at cycles 5 and 35 (during READ and DONE) → ignored; a second `start` at cycle 37 runs a full second check with cleared stats.
- `sys_rst` asserted at cycle 10 and released at cycle 12 → all outputs 0 by the next edge, no `done`; a new `start` at cycle 14 completes normally with `pass`=1.
- DEPTH=1 and SEED=0x10 → one read of 0x10, `done` at cycle 4, `pass`=1.

Source files
------------

// File: rtl/ram_test_pkg.sv
// Shared definitions for the RAM write/read test blocks: FSM encodings,
// the stored data pattern and the supported read-latency range.
package ram_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Word stored at an address; the caller truncates to its data width.
  function automatic logic [31:0] pattern_word(input logic [31:0] addr,
                                               input logic [31:0] seed);
    return addr + seed;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep valid/address delay line that tracks reads in flight so
// returning RAM data can be matched to the address that produced it.
module rd_tag_pipe #(
  parameter int AW     = 5,
  parameter int RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          vld_i,
  input  logic [AW-1:0] addr_i,
  output logic          vld_o,
  output logic [AW-1:0] addr_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [AW-1:0]     addr_q [RD_LAT];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) addr_q[i] <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      addr_q[0] <= addr_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[RD_LAT-1];
  assign addr_o = addr_q[RD_LAT-1];

endmodule

// File: rtl/ram_rd_checker.sv
// Sweeps the RAM 0..DEPTH-1 after start, streams each word out and checks it
// against the writer's pattern, reporting error count and first bad address.
//   state    | meaning
//   ST_IDLE  | waiting for start, RAM port released
//   ST_READ  | issuing one read address per cycle
//   ST_DRAIN | waiting RD_LAT+1 cycles for in-flight reads to be compared
//   ST_DONE  | one-cycle done pulse, pass latched
module ram_rd_checker #(
  parameter int DW     = 8,
  parameter int AW     = 5,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1,
  parameter int SEED   = 0
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          start,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_dout,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_cnt,
  output logic [AW-1:0] first_err_addr
);

  import ram_test_pkg::*;

  localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
  localparam logic [1:0]    DRAIN_LOAD = 2'(RD_LAT);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("ram_rd_checker: RD_LAT must be 1 or 2");
  end

  rd_state_e     state_q;
  logic [AW-1:0] rd_ptr_q;
  logic [1:0]    drain_cnt_q;
  logic          ram_en_q, busy_q, done_q, pass_q;
  logic          start_acc;

  logic          tag_vld;
  logic [AW-1:0] tag_addr;
  logic [DW-1:0] exp_word;

  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;
  logic [AW:0]   err_cnt_q, err_cnt_d;
  logic [AW-1:0] first_err_q, first_err_d;
  logic          err_seen_q, err_seen_d;

  assign start_acc = start && (state_q == ST_IDLE);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      rd_ptr_q    <= '0;
      drain_cnt_q <= '0;
      ram_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q  <= ST_READ;
            rd_ptr_q <= '0;
            ram_en_q <= 1'b1;
            busy_q   <= 1'b1;
            pass_q   <= 1'b0;
          end
        end
        ST_READ: begin
          if (rd_ptr_q == LAST_ADDR) begin
            state_q     <= ST_DRAIN;
            ram_en_q    <= 1'b0;
            drain_cnt_q <= DRAIN_LOAD;
          end else begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          // err_cnt already holds the last compare in the final drain cycle.
          if (drain_cnt_q == 2'd0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_q == '0);
          end else begin
            drain_cnt_q <= drain_cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  rd_tag_pipe #(
    .AW     (AW),
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .vld_i  (ram_en_q),
    .addr_i (rd_ptr_q),
    .vld_o  (tag_vld),
    .addr_o (tag_addr)
  );

  assign exp_word = DW'(pattern_word(32'(tag_addr), 32'(SEED)));

  always_comb begin
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    err_seen_d  = err_seen_q;
    if (start_acc) begin
      err_cnt_d   = '0;
      first_err_d = '0;
      err_seen_d  = 1'b0;
    end else if (tag_vld && (ram_dout != exp_word)) begin
      err_cnt_d = err_cnt_q + 1'b1;
      if (!err_seen_q) begin
        first_err_d = tag_addr;
        err_seen_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      err_seen_q  <= 1'b0;
    end else begin
      rd_valid_q  <= tag_vld;
      if (tag_vld) rd_data_q <= ram_dout;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      err_seen_q  <= err_seen_d;
    end
  end

  assign ram_en         = ram_en_q;
  assign ram_we         = 1'b0;
  assign ram_addr       = rd_ptr_q;
  assign rd_data        = rd_data_q;
  assign rd_valid       = rd_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_ram_rd_checker.sv
// Bench for ram_rd_checker: three configurations against behavioural RAMs and
// a cycle-indexed model of what each output must show after an accepted start.
module tb_ram_rd_checker;

  localparam int NI = 3;
  localparam int P_DEPTH [NI] = '{32, 32, 1};
  localparam int P_RDL   [NI] = '{1, 2, 1};
  localparam int P_SEED  [NI] = '{0, 0, 16};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_s [NI];
  logic       en_s [NI], we_s [NI], valid_s [NI], busy_s [NI], done_s [NI], pass_s [NI];
  logic [4:0] addr_s [NI], first_s [NI];
  logic [7:0] data_s [NI];
  logic [5:0] err_s [NI];
  logic [7:0] mem [NI][32];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int g, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s inst%0d cyc=%0d actual=%0d expected=%0d", nm, g, cyc, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : u
    localparam int DEPTH = P_DEPTH[g];
    localparam int RDL   = P_RDL[g];
    localparam int SEED  = P_SEED[g];
    localparam int LAST  = DEPTH + RDL + 2;

    logic [7:0] p1, p2, dout;
    logic [7:0] snap [32];
    bit         active;
    int         t0;

    ram_rd_checker #(
      .DW(8), .AW(5), .DEPTH(DEPTH), .RD_LAT(RDL), .SEED(SEED)
    ) dut (
      .sys_clk        (clk),
      .sys_rst        (rst),
      .start          (start_s[g]),
      .ram_en         (en_s[g]),
      .ram_we         (we_s[g]),
      .ram_addr       (addr_s[g]),
      .ram_dout       (dout),
      .rd_data        (data_s[g]),
      .rd_valid       (valid_s[g]),
      .busy           (busy_s[g]),
      .done           (done_s[g]),
      .pass           (pass_s[g]),
      .err_cnt        (err_s[g]),
      .first_err_addr (first_s[g])
    );

    // Behavioural RAM: garbage when not enabled, data RDL cycles after address.
    always @(posedge clk) begin
      p1 <= en_s[g] ? mem[g][addr_s[g]] : 8'($urandom);
      p2 <= p1;
    end
    assign dout = (RDL == 1) ? p1 : p2;

    // Model: remember when a start was accepted and the RAM contents for that run.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        active <= 1'b0;
      end else if (start_s[g] && (!active || (cyc - t0) >= LAST + 1)) begin
        active <= 1'b1;
        t0     <= cyc;
        for (int k = 0; k < 32; k++) snap[k] <= mem[g][k];
      end
    end

    always @(negedge clk) begin : cmp
      int rel, nk, ne, fe;
      bit inrun, vexp;
      if (!rst) begin
        rel   = cyc - t0;
        inrun = active && (rel <= LAST);
        nk    = 0;
        if (active) begin
          nk = rel - RDL - 1;
          if (nk < 0) nk = 0;
          if (nk > DEPTH) nk = DEPTH;
        end
        ne = 0;
        fe = 0;
        for (int k = 0; k < nk; k++) begin
          if (snap[k] != 8'(k + SEED)) begin
            if (ne == 0) fe = k;
            ne++;
          end
        end
        vexp = inrun && (rel >= RDL + 2) && (rel <= DEPTH + RDL + 1);
        chk("busy", g, busy_s[g], inrun);
        chk("done", g, done_s[g], inrun && rel == LAST);
        chk("ram_en", g, en_s[g], inrun && rel <= DEPTH);
        chk("ram_we", g, we_s[g], 0);
        if (inrun && rel <= DEPTH) chk("ram_addr", g, addr_s[g], rel - 1);
        chk("rd_valid", g, valid_s[g], vexp);
        if (vexp) chk("rd_data", g, data_s[g], snap[rel - RDL - 2]);
        chk("err_cnt", g, err_s[g], ne);
        chk("first_err_addr", g, first_s[g], fe);
        chk("pass", g, pass_s[g], active && rel >= LAST && ne == 0);
      end
    end
  end

  task automatic restore(input int g);
    for (int a = 0; a < 32; a++) mem[g][a] = 8'(a + P_SEED[g]);
  endtask

  // Pulses start now, optionally re-pulses during the run, returns one cycle
  // after done with start low.
  task automatic run_check(input int g, input int pa, input int pb, input bit noise,
                           output int done_rel, output int fv_rel, output int fv_data);
    done_rel = -1;
    fv_rel   = -1;
    fv_data  = -1;
    start_s[g] = 1'b1;
    for (int rel = 1; rel <= 200; rel++) begin
      @(negedge clk);
      start_s[g] = (rel == pa) || (rel == pb) || (noise && $urandom_range(0, 7) == 0);
      if (fv_rel < 0 && valid_s[g]) begin
        fv_rel  = rel;
        fv_data = data_s[g];
      end
      if (done_s[g]) begin
        done_rel = rel;
        break;
      end
    end
    @(negedge clk);
    start_s[g] = 1'b0;
    if (done_rel < 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout inst%0d: no done within 200 cycles", g);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dr, fv, fd;
    bit seen;
    for (int g = 0; g < NI; g++) begin
      start_s[g] = 1'b0;
      restore(g);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_pass", 0, pass_s[0], 0);
    chk("reset_err", 0, err_s[0], 0);
    chk("reset_busy", 0, busy_s[0], 0);

    // Clean sweep, RD_LAT=1.
    run_check(0, -1, -1, 1'b0, dr, fv, fd);
    chk("t1_done_cycle", 0, dr, 35);
    chk("t1_first_valid", 0, fv, 3);
    chk("t1_first_data", 0, fd, 0);
    chk("t1_pass", 0, pass_s[0], 1);
    chk("t1_err", 0, err_s[0], 0);

    // Two corrupted words, with start re-pulsed in READ and DONE.
    mem[0][7]  = 8'hFF;
    mem[0][20] = 8'h00;
    run_check(0, 5, 35, 1'b0, dr, fv, fd);
    chk("t2_done_cycle", 0, dr, 35);
    chk("t2_err", 0, err_s[0], 2);
    chk("t2_first_err", 0, first_s[0], 7);
    chk("t2_pass", 0, pass_s[0], 0);
    restore(0);
    @(negedge clk);
    run_check(0, -1, -1, 1'b0, dr, fv, fd);
    chk("t4_done_cycle", 0, dr, 35);
    chk("t4_err_cleared", 0, err_s[0], 0);
    chk("t4_first_cleared", 0, first_s[0], 0);
    chk("t4_pass", 0, pass_s[0], 1);

    // RD_LAT=2.
    run_check(1, -1, -1, 1'b0, dr, fv, fd);
    chk("t3_done_cycle", 1, dr, 36);
    chk("t3_first_valid", 1, fv, 4);
    chk("t3_pass", 1, pass_s[1], 1);

    // Reset mid-run.
    mem[0][3] = 8'hAA;
    start_s[0] = 1'b1;
    seen = 1'b0;
    for (int rel = 1; rel < 14; rel++) begin
      @(negedge clk);
      start_s[0] = 1'b0;
      if (done_s[0]) seen = 1'b1;
      if (rel == 10) begin
        chk("t5_err_before_rst", 0, err_s[0], 1);
        rst = 1'b1;
      end
      if (rel == 11) begin
        chk("t5_busy_rst", 0, busy_s[0], 0);
        chk("t5_en_rst", 0, en_s[0], 0);
        chk("t5_valid_rst", 0, valid_s[0], 0);
        chk("t5_err_rst", 0, err_s[0], 0);
        chk("t5_first_rst", 0, first_s[0], 0);
      end
      if (rel == 12) rst = 1'b0;
    end
    chk("t5_no_done", 0, seen, 0);
    restore(0);
    @(negedge clk);
    run_check(0, -1, -1, 1'b0, dr, fv, fd);
    chk("t5_done_cycle", 0, dr, 35);
    chk("t5_pass", 0, pass_s[0], 1);

    // DEPTH=1, SEED=0x10.
    run_check(2, -1, -1, 1'b0, dr, fv, fd);
    chk("t6_done_cycle", 2, dr, 4);
    chk("t6_first_valid", 2, fv, 3);
    chk("t6_data", 2, fd, 16);
    chk("t6_pass", 2, pass_s[2], 1);

    // Randomised corruption and start noise across all configurations.
    for (int it = 0; it < 15; it++) begin
      int g;
      g = $urandom_range(0, NI - 1);
      for (int a = 0; a < 32; a++)
        if ($urandom_range(0, 9) == 0) mem[g][a] = 8'($urandom);
      run_check(g, -1, -1, 1'b1, dr, fv, fd);
      chk("rand_done_cycle", g, dr, P_DEPTH[g] + P_RDL[g] + 2);
      restore(g);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
